// File: rtl/dm_csr_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_csr_access_pkg
// Description : Shared types and constants for the debug-module abstract
//               access-register path to the core CSR port.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_csr_access_pkg;

   // Abstract command error codes reported in cmderr
   localparam logic [2:0] c_CMDERR_NONE       = 3'd0;
   localparam logic [2:0] c_CMDERR_BUSY       = 3'd1;
   localparam logic [2:0] c_CMDERR_NOTSUP     = 3'd2;
   localparam logic [2:0] c_CMDERR_EXCEPTION  = 3'd3;
   localparam logic [2:0] c_CMDERR_HALTRESUME = 3'd4;

   // funct3 encodings presented on the CSR port
   localparam logic [2:0] c_F3_CSRRW = 3'b001;
   localparam logic [2:0] c_F3_CSRRS = 3'b010;

   // Abstract register numbers that map onto CSRs
   localparam logic [15:0] c_REGNO_CSR_FIRST = 16'h0000;
   localparam logic [15:0] c_REGNO_CSR_LAST  = 16'h0FFF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // The CSR window starts at zero, so only the upper bound needs a compare
   function automatic logic regno_is_csr(input logic [15:0] regno);
      return (regno <= c_REGNO_CSR_LAST);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_csr_access_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_csr_access_if
// Description : Command, status, data0 and CSR-port signals of the abstract
//               CSR access block. slave = access block, master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_csr_access_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_regno;
   logic        cmd_write;
   logic        cmd_transfer;
   logic        cmd_postinc;

   logic [31:0] data0_in;
   logic [31:0] data0_out;
   logic        data0_we;

   logic        busy;
   logic        done;
   logic [2:0]  cmderr;
   logic [2:0]  cmderr_clr;

   logic        halted;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [2:0]  csr_f3;
   logic [4:0]  csr_rs;
   logic        csr_write;
   logic        csr_debug;
   logic [31:0] csr_rdata;
   logic        csr_invalid;
   logic        csr_conflict;

   logic [15:0] regno_next;
   logic        regno_we;

   modport slave (
      input  cmd_valid, cmd_regno, cmd_write, cmd_transfer, cmd_postinc,
      input  data0_in, cmderr_clr, halted, csr_rdata, csr_invalid, csr_conflict,
      output cmd_ready, data0_out, data0_we, busy, done, cmderr,
      output csr_addr, csr_wdata, csr_f3, csr_rs, csr_write, csr_debug,
      output regno_next, regno_we
   );

   modport master (
      output cmd_valid, cmd_regno, cmd_write, cmd_transfer, cmd_postinc,
      output data0_in, cmderr_clr, halted, csr_rdata, csr_invalid, csr_conflict,
      input  cmd_ready, data0_out, data0_we, busy, done, cmderr,
      input  csr_addr, csr_wdata, csr_f3, csr_rs, csr_write, csr_debug,
      input  regno_next, regno_we
   );

endinterface
`default_nettype wire

// File: rtl/dm_csr_access.sv
`default_nettype none
// ============================================================================
// Module      : dm_csr_access
// Description : Executes abstract access-register commands against the core
//               CSR port: error screening at accept, conflict back-off with
//               abort, read capture into data0, sticky W1C cmderr.
//               Optional macro DM_CSR_POSTINC_EN enables regno postincrement.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_csr_access
   import dm_csr_access_pkg::*;
#(
   parameter int CONFLICT_LIMIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   dm_csr_access_if.slave   bus
);

   localparam int CW = $clog2(CONFLICT_LIMIT + 1);

   state_t          r_state;
   state_t          w_state_next;
   logic [15:0]     r_regno;
   logic            r_write;
   logic            r_transfer;
   logic [31:0]     r_wdata;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic [2:0]      r_cmderr;
   logic [2:0]      w_err_set;
   logic [31:0]     r_data0;
   logic            r_data0_we;
   logic            w_accept;
   logic            w_csr_write;
   logic            w_rd_capture;
   logic            w_in_access;

   assign w_accept    = bus.cmd_valid && (r_state == S_IDLE);
   assign w_in_access = (r_state == S_ACCESS);

   // Next-state, conflict counting and error generation
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_err_set    = c_CMDERR_NONE;
      w_csr_write  = 1'b0;
      w_rd_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cnt_next = '0;
               if (!regno_is_csr(bus.cmd_regno)) begin
                  w_err_set = w_err_set | c_CMDERR_NOTSUP;
               end
               if (!bus.halted) begin
                  w_err_set = w_err_set | c_CMDERR_HALTRESUME;
               end
               // Any pending or new error turns the command into a no-op
               if (bus.cmd_transfer && (r_cmderr == c_CMDERR_NONE) &&
                   (w_err_set == c_CMDERR_NONE)) begin
                  w_state_next = S_ACCESS;
               end else begin
                  w_state_next = S_DONE;
               end
            end
         end
         S_ACCESS: begin
            if (bus.csr_conflict) begin
               w_cnt_next = r_cnt + CW'(1);
               if (w_cnt_next == CW'(CONFLICT_LIMIT)) begin
                  w_err_set    = c_CMDERR_BUSY;
                  w_state_next = S_DONE;
               end
            end else if (bus.csr_invalid) begin
               w_err_set    = c_CMDERR_EXCEPTION;
               w_state_next = S_DONE;
            end else begin
               w_csr_write  = r_write;
               w_rd_capture = !r_write;
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State, command latch, counter, sticky cmderr and data0 capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_regno    <= '0;
         r_write    <= 1'b0;
         r_transfer <= 1'b0;
         r_wdata    <= '0;
         r_cnt      <= '0;
         r_cmderr   <= c_CMDERR_NONE;
         r_data0    <= '0;
         r_data0_we <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         // Set is applied after clear so a coincident set survives
         r_cmderr   <= (r_cmderr & ~bus.cmderr_clr) | w_err_set;
         r_data0_we <= w_rd_capture;
         if (w_rd_capture) begin
            r_data0 <= bus.csr_rdata;
         end
         if (w_accept) begin
            r_regno    <= bus.cmd_regno;
            r_write    <= bus.cmd_write;
            r_transfer <= bus.cmd_transfer;
            r_wdata    <= bus.data0_in;
         end
      end
   end

   // Status outputs; reset forces them low immediately
   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.busy      = rst_n && (r_state != S_IDLE);
   assign bus.done      = rst_n && (r_state == S_DONE);
   assign bus.cmderr    = r_cmderr;
   assign bus.data0_out = r_data0;
   assign bus.data0_we  = r_data0_we;

   // CSR port is only driven while an access is in flight
   assign bus.csr_addr  = w_in_access ? r_regno[11:0] : 12'h000;
   assign bus.csr_debug = w_in_access;
   assign bus.csr_f3    = !w_in_access ? 3'b000 : (r_write ? c_F3_CSRRW : c_F3_CSRRS);
   assign bus.csr_wdata = (w_in_access && r_write) ? r_wdata : 32'h0000_0000;
   assign bus.csr_rs    = 5'd0;
   assign bus.csr_write = rst_n && w_csr_write;

`ifdef DM_CSR_POSTINC_EN
   logic r_postinc;
   logic r_err;
   logic w_inc_fire;

   // Remember postinc request and whether this command hit any error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_postinc <= 1'b0;
         r_err     <= 1'b0;
      end else if (w_accept) begin
         r_postinc <= bus.cmd_postinc;
         r_err     <= (r_cmderr != c_CMDERR_NONE) || (w_err_set != c_CMDERR_NONE);
      end else if (w_err_set != c_CMDERR_NONE) begin
         r_err     <= 1'b1;
      end
   end

   assign w_inc_fire     = rst_n && (r_state == S_DONE) && r_postinc && r_transfer && !r_err;
   assign bus.regno_we   = w_inc_fire;
   assign bus.regno_next = w_inc_fire ? (r_regno + 16'd1) : 16'h0000;
`else
   assign bus.regno_we   = 1'b0;
   assign bus.regno_next = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_csr_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_csr_access
// Description : Self-checking bench for dm_csr_access: vector table with a
//               scoreboard queue, plus reset and reset-mid-access sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_csr_access;
   import dm_csr_access_pkg::*;

   localparam int LIMIT = 16;
   localparam int NVEC  = 16;
`ifdef DM_CSR_POSTINC_EN
   localparam int PI = 1;
`else
   localparam int PI = 0;
`endif

   typedef struct {
      logic [15:0] regno;
      logic        write;
      logic        transfer;
      logic        postinc;
      logic        halted;
      logic [31:0] data;
      logic [31:0] rdata;
      logic        invalid;
      int          conf;
      logic [2:0]  clr_during;
      logic [2:0]  clr_after;
      int          lat;
      logic        acc;
      int          nwr;
      int          nwe;
      logic [31:0] d0;
      logic [2:0]  err;
      int          nrwe;
      logic [15:0] rnext;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   dm_csr_access_if bus();

   dm_csr_access #(.CONFLICT_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   issued = 0;
   int   n_done = 0;
   bit   mon_en = 1'b0;
   vec_t exp_q[$];
   vec_t vecs[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [15:0] regno, input logic write, input logic transfer,
      input logic postinc, input logic halted, input logic [31:0] data,
      input logic [31:0] rdata, input logic invalid, input int conf,
      input logic [2:0] clr_during, input logic [2:0] clr_after, input int lat,
      input logic acc, input int nwr, input int nwe, input logic [31:0] d0,
      input logic [2:0] err, input int nrwe, input logic [15:0] rnext);
      vec_t v;
      v.regno = regno; v.write = write; v.transfer = transfer; v.postinc = postinc;
      v.halted = halted; v.data = data; v.rdata = rdata; v.invalid = invalid;
      v.conf = conf; v.clr_during = clr_during; v.clr_after = clr_after;
      v.lat = lat; v.acc = acc; v.nwr = nwr; v.nwe = nwe; v.d0 = d0;
      v.err = err; v.nrwe = nrwe; v.rnext = rnext;
      return v;
   endfunction

   // Monitor: observe each accepted command and score it at done
   bit          in_cmd = 1'b0;
   int          cyc, busy_n, wr_n, we_n, rwe_n;
   logic [31:0] d0_seen, wd_seen;
   logic [15:0] rn_seen;
   logic [11:0] addr_seen;
   logic [2:0]  f3_seen;
   logic [4:0]  rs_seen;
   logic        acc_seen;
   vec_t        e;

   initial forever begin
      @(negedge clk);
      if (!mon_en) begin
         in_cmd = 1'b0;
      end else if (in_cmd) begin
         cyc++;
         if (bus.busy)      busy_n++;
         if (bus.csr_write) wr_n++;
         if (bus.data0_we) begin we_n++;  d0_seen = bus.data0_out;  end
         if (bus.regno_we) begin rwe_n++; rn_seen = bus.regno_next; end
         if (bus.csr_debug) begin
            acc_seen  = 1'b1;
            f3_seen   = bus.csr_f3;
            addr_seen = bus.csr_addr;
            wd_seen   = bus.csr_wdata;
            rs_seen   = bus.csr_rs;
         end
         if (bus.done || cyc > 30) begin
            in_cmd = 1'b0;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL scoreboard: got done with empty queue expected none");
            end else begin
               e = exp_q.pop_front();
               chk("done_latency", cyc, e.lat);
               chk("busy_cycles", busy_n, e.lat);
               chk("csr_write_count", wr_n, e.nwr);
               chk("data0_we_count", we_n, e.nwe);
               if (e.nwe > 0) chk("data0_out", d0_seen, e.d0);
               chk("cmderr", {29'd0, bus.cmderr}, {29'd0, e.err});
               chk("access_seen", {31'd0, acc_seen}, {31'd0, e.acc});
               if (e.acc) begin
                  chk("csr_f3", {29'd0, f3_seen}, e.write ? 32'd1 : 32'd2);
                  chk("csr_addr", {20'd0, addr_seen}, {20'd0, e.regno[11:0]});
                  chk("csr_wdata", wd_seen, e.write ? e.data : 32'h0);
                  chk("csr_rs", {27'd0, rs_seen}, 32'd0);
               end
               chk("regno_we_count", rwe_n, e.nrwe);
               if (e.nrwe > 0) chk("regno_next", {16'd0, rn_seen}, {16'd0, e.rnext});
            end
            n_done++;
         end
      end else if (bus.cmd_valid && bus.cmd_ready) begin
         in_cmd   = 1'b1;
         cyc      = 0;
         busy_n   = 0;
         wr_n     = 0;
         we_n     = 0;
         rwe_n    = 0;
         acc_seen = 1'b0;
      end
   end

   task automatic run_vec(input vec_t v);
      @(posedge clk); #1;
      bus.cmd_regno    = v.regno;
      bus.cmd_write    = v.write;
      bus.cmd_transfer = v.transfer;
      bus.cmd_postinc  = v.postinc;
      bus.halted       = v.halted;
      bus.data0_in     = v.data;
      bus.csr_rdata    = v.rdata;
      bus.csr_invalid  = v.invalid;
      bus.csr_conflict = (v.conf > 0);
      bus.cmderr_clr   = v.clr_during;
      bus.cmd_valid    = 1'b1;
      exp_q.push_back(v);
      issued++;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if (v.conf > 0) begin
         repeat (v.conf) @(posedge clk);
         #1;
         bus.csr_conflict = 1'b0;
      end
      for (int k = 0; k < 60; k++) begin
         if (n_done >= issued) break;
         @(posedge clk);
      end
      if (n_done < issued) begin
         checks++; errors++;
         $display("FAIL cmd_timeout: got %0d completions expected %0d", n_done, issued);
         n_done = issued;
         exp_q.delete();
      end
      #1;
      bus.cmderr_clr  = 3'b000;
      bus.csr_invalid = 1'b0;
      if (v.clr_after != 3'b000) begin
         @(posedge clk); #1;
         bus.cmderr_clr = v.clr_after;
         @(posedge clk); #1;
         bus.cmderr_clr = 3'b000;
         chk("cmderr_after_clear", {29'd0, bus.cmderr}, 32'd0);
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.cmd_valid    = 1'b0;
      bus.cmd_regno    = '0;
      bus.cmd_write    = 1'b0;
      bus.cmd_transfer = 1'b0;
      bus.cmd_postinc  = 1'b0;
      bus.data0_in     = '0;
      bus.cmderr_clr   = '0;
      bus.halted       = 1'b1;
      bus.csr_rdata    = '0;
      bus.csr_invalid  = 1'b0;
      bus.csr_conflict = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_cmderr", {29'd0, bus.cmderr}, 32'd0);
      chk("rst_data0_out", bus.data0_out, 32'd0);
      chk("rst_data0_we", {31'd0, bus.data0_we}, 32'd0);
      chk("rst_csr_write", {31'd0, bus.csr_write}, 32'd0);
      chk("rst_regno_we", {31'd0, bus.regno_we}, 32'd0);
      chk("rst_regno_next", {16'd0, bus.regno_next}, 32'd0);
      rst_n = 1'b1;

      //            regno     wr tr pi ha data          rdata         inv conf cd   ca     lat acc nwr nwe d0            err nrwe rnext
      vecs[0]  = mk(16'h0300, 0, 1, 0, 1, 32'h0,        32'h00001800, 0,  0,  3'd0, 3'd0,  2, 1, 0, 1, 32'h00001800, 3'd0, 0,  16'h0);
      vecs[1]  = mk(16'h0341, 1, 1, 0, 1, 32'h80000004, 32'h0,        0,  0,  3'd0, 3'd0,  2, 1, 1, 0, 32'h0,        3'd0, 0,  16'h0);
      vecs[2]  = mk(16'h0342, 1, 1, 0, 1, 32'hA5A5A5A5, 32'h0,        1,  0,  3'd0, 3'd0,  2, 1, 0, 0, 32'h0,        3'd3, 0,  16'h0);
      vecs[3]  = mk(16'h0300, 0, 1, 0, 1, 32'h0,        32'h11111111, 0,  0,  3'd0, 3'd7,  1, 0, 0, 0, 32'h0,        3'd3, 0,  16'h0);
      vecs[4]  = mk(16'h0305, 1, 1, 0, 1, 32'h12345678, 32'h0,        0,  3,  3'd0, 3'd0,  5, 1, 1, 0, 32'h0,        3'd0, 0,  16'h0);
      vecs[5]  = mk(16'h0306, 1, 1, 0, 1, 32'h9ABCDEF0, 32'h0,        0,  16, 3'd0, 3'd7, 17, 1, 0, 0, 32'h0,        3'd1, 0,  16'h0);
      vecs[6]  = mk(16'h1000, 0, 1, 0, 1, 32'h0,        32'h22222222, 0,  0,  3'd0, 3'd7,  1, 0, 0, 0, 32'h0,        3'd2, 0,  16'h0);
      vecs[7]  = mk(16'h0300, 0, 1, 0, 0, 32'h0,        32'h33333333, 0,  0,  3'd0, 3'd7,  1, 0, 0, 0, 32'h0,        3'd4, 0,  16'h0);
      vecs[8]  = mk(16'h0300, 0, 0, 0, 1, 32'h0,        32'h44444444, 0,  0,  3'd0, 3'd0,  1, 0, 0, 0, 32'h0,        3'd0, 0,  16'h0);
      vecs[9]  = mk(16'h0301, 0, 1, 0, 1, 32'h0,        32'h55555555, 1,  0,  3'd0, 3'd7,  2, 1, 0, 0, 32'h0,        3'd3, 0,  16'h0);
      vecs[10] = mk(16'hFFFF, 0, 1, 1, 1, 32'h0,        32'h66666666, 0,  0,  3'd0, 3'd7,  1, 0, 0, 0, 32'h0,        3'd2, 0,  16'h0);
      vecs[11] = mk(16'h0B00, 0, 1, 1, 1, 32'h0,        32'hDEADBEEF, 0,  0,  3'd0, 3'd0,  2, 1, 0, 1, 32'hDEADBEEF, 3'd0, PI, 16'h0B01);
      vecs[12] = mk(16'h07B0, 0, 1, 0, 1, 32'h0,        32'hCAFEF00D, 0,  15, 3'd0, 3'd0, 17, 1, 0, 1, 32'hCAFEF00D, 3'd0, 0,  16'h0);
      vecs[13] = mk(16'h0341, 1, 1, 1, 1, 32'h00000055, 32'h0,        0,  0,  3'd0, 3'd0,  2, 1, 1, 0, 32'h0,        3'd0, PI, 16'h0342);
      vecs[14] = mk(16'h0400, 0, 0, 1, 1, 32'h0,        32'h0,        0,  0,  3'd0, 3'd0,  1, 0, 0, 0, 32'h0,        3'd0, 0,  16'h0);
      vecs[15] = mk(16'h0343, 1, 1, 0, 1, 32'h00000077, 32'h0,        1,  0,  3'd7, 3'd7,  2, 1, 0, 0, 32'h0,        3'd3, 0,  16'h0);

      @(posedge clk); #1;
      chk("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
      mon_en = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         run_vec(vecs[i]);
      end
      mon_en = 1'b0;

      // Reset in the middle of a write access must abandon it silently
      @(posedge clk); #1;
      bus.cmd_regno    = 16'h0341;
      bus.cmd_write    = 1'b1;
      bus.cmd_transfer = 1'b1;
      bus.cmd_postinc  = 1'b0;
      bus.halted       = 1'b1;
      bus.data0_in     = 32'hFEEDFACE;
      bus.csr_invalid  = 1'b0;
      bus.csr_conflict = 1'b1;
      bus.cmd_valid    = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      chk("mid_busy_before_reset", {31'd0, bus.busy}, 32'd1);
      bus.csr_conflict = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_csr_write", {31'd0, bus.csr_write}, 32'd0);
      chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("mid_rst_cmderr", {29'd0, bus.cmderr}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("mid_rst_quiet", {30'd0, bus.done, bus.csr_write}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dm_csr_access.md
DM_CSR_ACCESS -- requirements
Module: dm_csr_access

Interface
REQ-001 SHALL have parameter CONFLICT_LIMIT, default 16: max consecutive conflict cycles before abort.
REQ-002 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock, reset is synchronous and active-low.
REQ-003 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_regno in 16, cmd_write in 1, cmd_transfer in 1, cmd_postinc in 1: abstract access-register command.
REQ-004 SHALL have ports data0_in in 32 (write data), data0_out out 32 (read data), data0_we out 1 (data0_out valid pulse).
REQ-005 SHALL have ports busy out 1, done out 1 (completion pulse), cmderr out 3 (sticky error), cmderr_clr in 3 (write-1-to-clear).
REQ-006 SHALL have ports halted in 1, csr_addr out 12, csr_wdata out 32, csr_f3 out 3, csr_rs out 5, csr_write out 1, csr_debug out 1, csr_rdata in 32, csr_invalid in 1, csr_conflict in 1: initiator side of the core CSR port.
REQ-007 SHALL have ports regno_next out 16 and regno_we out 1 (postincrement result).

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-009 cmd_ready SHALL equal (state==IDLE); command accepted on cmd_valid&&cmd_ready and latched.
REQ-010 Accept in IDLE at cycle N: go to ACCESS at N+1 if cmd_transfer=1, else DONE at N+1.
REQ-011 In ACCESS: csr_addr=regno[11:0], csr_debug=1; write: csr_f3=3'b001, csr_wdata=data0 latched at accept; read: csr_f3=3'b010, csr_rs=0, csr_wdata=0.
REQ-012 csr_write SHALL be asserted in ACCESS only when csr_conflict=0, csr_invalid=0 and the command is a write; 0 elsewhere.
REQ-013 ACCESS with csr_conflict=1: stay in ACCESS, increment conflict counter; counter reaching CONFLICT_LIMIT: cmderr|=3'd1 (busy), go to DONE without access.
REQ-014 ACCESS without conflict: read -> data0_out<=csr_rdata, data0_we pulse for exactly one cycle (at N+2 for single-cycle access); go to DONE.
REQ-015 csr_invalid=1 in ACCESS (no conflict): no write, no data0_we, cmderr|=3'd3 (exception), go to DONE.
REQ-016 At accept: regno[15:12]!=0 -> cmderr|=3'd2 (not supported); halted=0 -> cmderr|=3'd4 (halt/resume); either -> DONE at N+1 without access.
REQ-017 Command accepted with cmderr!=0 SHALL perform no access and go directly to DONE.
REQ-018 DONE: done=1 for one cycle, next state IDLE; busy=1 in ACCESS and DONE only.
REQ-019 cmderr bits SHALL clear where cmderr_clr=1; a same-cycle set wins over clear.
REQ-020 Conflict counter SHALL reset to 0 on every accept; width clog2(CONFLICT_LIMIT+1).

Reset
REQ-021 rst_n=0 SHALL force state IDLE, cmderr=0, data0_out=0, data0_we=0, done=0, busy=0, csr_write=0, regno_we=0, regno_next=0, conflict counter 0.
REQ-022 Reset mid-ACCESS SHALL abandon the access with no csr_write and no done.

Configuration
REQ-023 With DM_CSR_POSTINC_EN defined: in DONE, if cmd_postinc=1 and cmd_transfer=1 and no error occurred in this command, regno_next=regno+1 (16-bit wrap 0xFFFF->0x0000), regno_we=1 one cycle.
REQ-024 Without DM_CSR_POSTINC_EN: cmd_postinc ignored, regno_we=0, regno_next=0 constant.

Structure
REQ-025 Shared package SHALL hold: cmderr codes (NONE=0, BUSY=1, NOTSUP=2, EXCEPTION=3, HALTRESUME=4), f3 codes CSRRW=001/CSRRS=010, CSR regno range 0x0000-0x0FFF, FSM state enum.
REQ-026 No sub-module; single FSM plus counter in one module.

Verification
REQ-027 Halted, read regno=0x0300, csr_rdata=0x00001800 -> csr_f3=010, csr_rs=0, csr_write=0, data0_out=0x00001800, data0_we at N+2, done at N+2.
REQ-028 Halted, write regno=0x0341 data0_in=0x80000004 -> csr_f3=001, csr_wdata=0x80000004, csr_write=1 one cycle, no data0_we, cmderr=0.
REQ-029 Write with csr_invalid=1 -> csr_write=0, cmderr=3; second command -> no access, done next cycle; cmderr_clr=3'b111 -> cmderr=0.
REQ-030 csr_conflict held 3 cycles then low -> busy 5 cycles, single csr_write; held 16 cycles -> cmderr=1, csr_write never asserted.
REQ-031 regno=0x1000 -> cmderr=2; halted=0 -> cmderr=4; transfer=0 -> done at N+1, no access.
REQ-032 DM_CSR_POSTINC_EN, postinc read regno=0xFFFF... rejected (cmderr=2, no regno_we); regno=0x0B00 success -> regno_next=0x0B01, regno_we one cycle.
